i2c_bus_sniffer: RTL
====================

// Module: i2c_bus_sniffer
// PURPOSE
//  Passive I2C monitor. Consumes the raw SCL/SDA probe pins and the PLL clock from the board top level.
//  Decodes START, repeated START, STOP and data bytes with their ACK bit. Never drives the bus.
//  Buffers decoded events in a FIFO and presents them on a valid/ready stream for capture or UART dump.
// PARAMETERS
//  SYNC_STAGES  2   synchroniser flops per pin (>=2)
//  FILT_LEN     4   consecutive equal samples needed to accept a pin change (filter build only)
//  FIFO_DEPTH   16  event FIFO entries, power of 2
// PORTS
//  clk_50M   in   1  system clock (PLL c2), all logic on rising edge
//  rst       in   1  synchronous, active-high reset
//  SCL       in   1  raw I2C clock pin, asynchronous
//  SDA       in   1  raw I2C data pin, asynchronous
//  ev_valid  out  1  FIFO head event available
//  ev_ready  in   1  consumer accepts head event
//  ev_type   out  2  0=START 1=STOP 2=BYTE 3=RSTART
//  ev_data   out  8  byte value, MSB first on bus; 0 for non-BYTE events
//  ev_ack    out  1  9th-bit SDA level (0=ACK, 1=NACK); 0 for non-BYTE events
//  overflow  out  1  sticky; event dropped because FIFO full; cleared only by rst
//  busy      out  1  high from START until STOP
// BEHAVIOUR
//  - Reset values: ev_valid=0, ev_type=0, ev_data=0, ev_ack=0, overflow=0, busy=0.
//    Sync/filter flops preset to 1 (idle bus). FIFO emptied. FSM=IDLE.
//  - Arm: detection is suppressed for SYNC_STAGES+FILT_LEN cycles after rst deassertion.
//    A low pin at reset release must not produce a false START.
//  - Condition detection on filtered lines s/d; previous-cycle values sp/dp.
//    START: sp=1, s=1, dp=1, d=0.  STOP: sp=1, s=1, dp=0, d=1.
//    If SCL and SDA change in the same cycle, treat it as a data change, not START/STOP.
//  - Bits are sampled on the SCL rise (sp=0, s=1). SCL falls carry no action.
//  - FSM states IDLE, DATA, ACK:
//    IDLE: START -> push START, busy=1, bitcnt=0, go DATA. SCL rises are ignored.
//    DATA: SCL rise -> shift d into byte register, bitcnt++. At bitcnt=7 -> go ACK.
//    ACK: SCL rise -> push BYTE{data, ack=d}, bitcnt=0, go DATA.
//    DATA/ACK: START -> push RSTART, discard partial byte, bitcnt=0, stay DATA.
//    Any state: STOP -> push STOP, busy=0, go IDLE. A partial byte is discarded with no BYTE event.
//  - Latency: ev_valid rises SYNC_STAGES+2 clocks after the first clock edge that samples the new pin level.
//    Add FILT_LEN when the filter is built in.
//  - FIFO: write on event push; pop when ev_valid && ev_ready. Outputs show the head entry.
//    Full and push -> event dropped, overflow<=1.
//    Full with simultaneous push and pop -> both occur, no overflow.
//    Empty -> ev_valid=0; the stream is first-word-fall-through, so no bypass is needed.
//    Pointers wrap modulo FIFO_DEPTH, with an extra bit for full/empty.
//  - Events are always written in detection order. At most one event is pushed per clock.
//  - rst mid-transfer: everything returns to reset values and FIFO contents are lost.
//    The byte in progress is lost. Decoding resumes at the next START after arm.
// CONFIGURATION
//  - I2C_SNIFF_GLITCH_FILTER_EN defined: a per-line counter accepts a new level only after
//    FILT_LEN consecutive identical synchronised samples. Shorter pulses are ignored entirely.
//  - Not defined: the filtered line equals the synchronised line, FILT_LEN is unused, and the
//    arm period is SYNC_STAGES cycles.
// STRUCTURE
//  - Package i2c_sniff_pkg holds:
//    ev_type_e enum (START, STOP, BYTE, RSTART);
//    i2c_ev_t packed struct {ev_type_e type; logic [7:0] data; logic ack;} (11 bits);
//    sniff_state_e enum (IDLE, DATA, ACK).
//  - Sub-module i2c_sniff_fifo: a generic synchronous FIFO of i2c_ev_t with depth param,
//    full/empty flags and first-word-fall-through output. Synchroniser, filter and FSM stay inline.
// TESTING
//  1. START, 0xA0, ACK, STOP with ev_ready=1
//     -> events START; BYTE data=0xA0 ack=0; STOP. busy goes 1 then 0.
//  2. START, 0x5A with SDA=1 on the 9th clock, STOP
//     -> BYTE data=0x5A ack=1.
//  3. START, 3 data bits, repeated START, 0x91 ACK, STOP
//     -> START, RSTART, BYTE 0x91 ack=0, STOP. No event for the partial byte.
//  4. ev_ready=0, 20 events, FIFO_DEPTH=16
//     -> first 16 retained in order, overflow=1, events 17-20 dropped.
//     Then ev_ready=1 drains exactly 16 entries.
//  5. Filter built, FILT_LEN=4, 2-cycle low glitch on SCL mid-byte
//     -> no extra bit, byte decoded correctly. Without the macro -> the glitch is counted as a bit.
//  6. rst held 1 cycle mid-byte with SDA=0, SCL=1, then released
//     -> all outputs at reset values, no START event. The next real START decodes normally.

Source files
------------

// File: rtl/i2c_sniff_pkg.sv
// Shared types for the passive I2C bus sniffer: event tags, the 11-bit
// event record stored in the FIFO, and the decoder state encoding.
package i2c_sniff_pkg;

    typedef enum logic [1:0] {
        EV_START  = 2'd0,
        EV_STOP   = 2'd1,
        EV_BYTE   = 2'd2,
        EV_RSTART = 2'd3
    } ev_type_e;

    // 'type' is a reserved word, so the tag field is named ev_type.
    typedef struct packed {
        ev_type_e   ev_type;
        logic [7:0] data;
        logic       ack;
    } i2c_ev_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ACK
    } sniff_state_e;

    function automatic i2c_ev_t mk_ev(input ev_type_e t, input logic [7:0] d, input logic a);
        i2c_ev_t e;
        e.ev_type = t;
        e.data    = d;
        e.ack     = a;
        return e;
    endfunction

endpackage

// File: rtl/i2c_sniff_fifo.sv
// Synchronous first-word-fall-through FIFO of i2c_ev_t records.
// Pointers carry one extra wrap bit to tell full from empty.
// A write while full is accepted only when a read happens in the same cycle.
module i2c_sniff_fifo
    import i2c_sniff_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    wr_en_i,
    input  i2c_ev_t wr_data_i,
    input  logic    rd_en_i,
    output i2c_ev_t rd_data_o,
    output logic    full_o,
    output logic    empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    i2c_ev_t     mem_q [DEPTH];
    logic        wr_fire;
    logic        rd_fire;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign wr_fire   = wr_en_i && (!full_o || rd_en_i);
    assign rd_fire   = rd_en_i && !empty_o;
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update; both may advance in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_fire) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage write; contents need no reset since reads are gated by empty.
    always_ff @(posedge clk_i) begin
        if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/i2c_bus_sniffer.sv
// Passive I2C monitor: synchronises SCL/SDA, optionally glitch-filters them,
// decodes START / repeated START / STOP / data bytes with ACK, and queues
// the events on a valid/ready stream. Never drives the bus.
// Optional feature macro: I2C_SNIFF_GLITCH_FILTER_EN (per-line FILT_LEN filter).
module i2c_bus_sniffer
    import i2c_sniff_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 4,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic       clk_50M,
    input  logic       rst,
    input  logic       SCL,
    input  logic       SDA,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [1:0] ev_type,
    output logic [7:0] ev_data,
    output logic       ev_ack,
    output logic       overflow,
    output logic       busy
);

`ifdef I2C_SNIFF_GLITCH_FILTER_EN
    localparam bit FILT_EN = 1'b1;
`else
    localparam bit FILT_EN = 1'b0;
`endif
    localparam int unsigned FILT_STAGES = FILT_EN ? FILT_LEN : 0;
    // Sync chain + filter, plus the line and previous-line registers that must
    // settle before a level difference can be trusted as a bus condition.
    localparam int unsigned ARM_MAX = SYNC_STAGES + FILT_STAGES + 2;
    localparam int unsigned ARM_W   = $clog2(ARM_MAX + 1);

    // Bit 1 = SCL, bit 0 = SDA throughout.
    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic [1:0]             line_sync;
    logic [1:0]             line_filt;
    logic [1:0]             line_q;
    logic [1:0]             line_prev_q;
    logic [ARM_W-1:0]       arm_cnt_q;
    logic                   armed;

    sniff_state_e state_q;
    logic [2:0]   bitcnt_q;
    logic [7:0]   shreg_q;
    logic         busy_q;
    logic         push_q;
    i2c_ev_t      ev_q;
    logic         overflow_q;

    logic    fifo_full;
    logic    fifo_empty;
    logic    pop;
    i2c_ev_t head;

    logic s, sp, d, dp;
    logic start_det, stop_det, rise_det;

    // Metastability synchronisers, preset to the idle (high) bus level.
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], SCL};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], SDA};
        end
    end

    assign line_sync = {scl_sync_q[SYNC_STAGES-1], sda_sync_q[SYNC_STAGES-1]};

`ifdef I2C_SNIFF_GLITCH_FILTER_EN
    localparam int unsigned FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN + 1) : 1;

    logic [1:0]     filt_q;
    logic [FCW-1:0] fcnt_q [2];

    // Accept a new level only after FILT_LEN consecutive differing samples.
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            filt_q <= '1;
            for (int unsigned i = 0; i < 2; i++) fcnt_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (line_sync[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == FCW'(FILT_LEN - 1)) begin
                    filt_q[i] <= line_sync[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign line_filt = filt_q;
`else
    assign line_filt = line_sync;
`endif

    // Current and previous filtered line levels for edge/condition detection.
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            line_q      <= '1;
            line_prev_q <= '1;
        end else begin
            line_q      <= line_filt;
            line_prev_q <= line_q;
        end
    end

    // Arm counter: blocks detection while the preset pipeline flushes.
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            arm_cnt_q <= '0;
        end else if (!armed) begin
            arm_cnt_q <= arm_cnt_q + 1'b1;
        end
    end

    assign armed = (arm_cnt_q == ARM_W'(ARM_MAX));

    assign s  = line_q[1];
    assign d  = line_q[0];
    assign sp = line_prev_q[1];
    assign dp = line_prev_q[0];

    // START/STOP need SCL steady high, so a simultaneous SCL+SDA change is a data change.
    assign start_det = armed && sp && s && dp && !d;
    assign stop_det  = armed && sp && s && !dp && d;
    assign rise_det  = armed && !sp && s;

    // Protocol decoder with registered event push and busy flag.
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            busy_q   <= 1'b0;
            push_q   <= 1'b0;
            ev_q     <= '0;
        end else begin
            push_q <= 1'b0;
            if (stop_det) begin
                push_q   <= 1'b1;
                ev_q     <= mk_ev(EV_STOP, 8'h00, 1'b0);
                busy_q   <= 1'b0;
                bitcnt_q <= '0;
                state_q  <= ST_IDLE;
            end else if (start_det) begin
                push_q   <= 1'b1;
                ev_q     <= mk_ev((state_q == ST_IDLE) ? EV_START : EV_RSTART, 8'h00, 1'b0);
                busy_q   <= 1'b1;
                bitcnt_q <= '0;
                state_q  <= ST_DATA;
            end else if (rise_det) begin
                case (state_q)
                    ST_DATA: begin
                        shreg_q  <= {shreg_q[6:0], d};
                        bitcnt_q <= bitcnt_q + 1'b1;
                        if (bitcnt_q == 3'd7) state_q <= ST_ACK;
                    end
                    ST_ACK: begin
                        push_q   <= 1'b1;
                        ev_q     <= mk_ev(EV_BYTE, shreg_q, d);
                        bitcnt_q <= '0;
                        state_q  <= ST_DATA;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign pop = ev_valid && ev_ready;

    // Sticky overflow: a push lost because the FIFO was full with no pop.
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (push_q && fifo_full && !pop) begin
            overflow_q <= 1'b1;
        end
    end

    i2c_sniff_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_50M),
        .rst_i     (rst),
        .wr_en_i   (push_q),
        .wr_data_i (ev_q),
        .rd_en_i   (pop),
        .rd_data_o (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign ev_valid = !fifo_empty;
    assign ev_type  = ev_valid ? head.ev_type : EV_START;
    assign ev_data  = ev_valid ? head.data    : 8'h00;
    assign ev_ack   = ev_valid ? head.ack     : 1'b0;
    assign overflow = overflow_q;
    assign busy     = busy_q;

endmodule
